quad_encoder_gen: RTL and testbench

QUAD_ENCODER_GEN -- requirements
Module: quad_encoder_gen

---
 rtl/quad_encoder_gen_pkg.sv | 32 +++
 rtl/quad_encoder_gen_edge_interval_counter.sv | 34 +++
 rtl/quad_encoder_gen.sv | 114 +++++++++++
 tb/tb_quad_encoder_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_encoder_gen_pkg.sv
// Shared definitions for the quadrature encoder signal generator.
//   state_t      : two-state command FSM (IDLE / RUN)
//   phase_t      : 2-bit quadrature phase
//   phase_step   : advance the phase one edge in the given direction
//   phase_to_ti  : phase -> {ti1, ti2} Gray-code mapping (one bit changes per step)
package quad_encoder_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef logic [1:0] phase_t;

  // dir = 0 counts up (TI1 leads), dir = 1 counts down (TI2 leads).
  function automatic phase_t phase_step(input phase_t phase, input logic dir);
    return dir ? phase_t'(phase - 2'd1) : phase_t'(phase + 2'd1);
  endfunction

  // Returns {ti1, ti2}.
  function automatic logic [1:0] phase_to_ti(input phase_t phase);
    logic [1:0] ti;
    case (phase)
      2'd0:    ti = 2'b00;
      2'd1:    ti = 2'b10;
      2'd2:    ti = 2'b11;
      default: ti = 2'b01;
    endcase
    return ti;
  endfunction

endpackage

// File: rtl/quad_encoder_gen_edge_interval_counter.sv
// Edge interval counter: counts enabled cycles and raises tick_o on the cycle
// the count reaches period_i, then restarts from zero.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   clear_i  : restart the interval (command accepted)
//   run_i    : count this cycle (running, enabled, not aborted)
//   period_i : interval length in cycles, must be >= 1
//   tick_o   : combinational, high on the cycle an edge is due
module edge_interval_counter #(
  parameter int PER_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [PER_W-1:0] period_i,
  output logic             tick_o
);

  logic [PER_W-1:0] cnt_q;

  // Comparing against period-1 makes the edge land on the period-th counted
  // cycle, so period 1 yields one edge every cycle.
  assign tick_o = run_i && (cnt_q == period_i - PER_W'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + PER_W'(1);
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder signal generator. Accepts a command (direction, number of
// edges, edge interval) and emits that many quadrature edges on ti1_o/ti2_o,
// tracking a signed position. Phase and position persist across commands.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   en_i              : global enable (pauses timing, blocks new commands)
//   cmd_valid_i/ready : command handshake
//   cmd_dir_i         : 0 = up, 1 = down
//   cmd_steps_i       : number of edges (0 completes immediately)
//   period_i          : cycles between edges (0 behaves as 1)
//   abort_i           : cancel a running command without done_o
//   ti1_o, ti2_o      : registered quadrature outputs
//   pos_o             : two's-complement edge position, wraps modulo 2^CNT_W
//   busy_o, done_o    : running flag, completion pulse
module quad_encoder_gen #(
  parameter int CNT_W = 16,
  parameter int PER_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_dir_i,
  input  logic [CNT_W-1:0] cmd_steps_i,
  input  logic [PER_W-1:0] period_i,
  input  logic             abort_i,
  output logic             ti1_o,
  output logic             ti2_o,
  output logic [CNT_W-1:0] pos_o,
  output logic             busy_o,
  output logic             done_o
);

  import quad_encoder_gen_pkg::*;

  state_t           state_q;
  phase_t           phase_q;
  logic             dir_q;
  logic [CNT_W-1:0] remaining_q;
  logic [PER_W-1:0] period_q;

  logic             accept;
  logic             run_en;
  logic             edge_tick;
  logic [PER_W-1:0] period_eff;
  phase_t           phase_nxt;

  assign cmd_ready_o = (state_q == IDLE) && en_i && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign busy_o      = (state_q == RUN);
  assign period_eff  = (period_i == '0) ? PER_W'(1) : period_i;
  assign phase_nxt   = phase_step(phase_q, dir_q);

  // Freezing the counter on abort is what lets abort win over a due edge.
  assign run_en = (state_q == RUN) && en_i && !abort_i;

  edge_interval_counter #(
    .PER_W (PER_W)
  ) u_interval (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (accept),
    .run_i    (run_en),
    .period_i (period_q),
    .tick_o   (edge_tick)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      dir_q       <= 1'b0;
      remaining_q <= '0;
      period_q    <= PER_W'(1);
      ti1_o       <= 1'b0;
      ti2_o       <= 1'b0;
      pos_o       <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            dir_q       <= cmd_dir_i;
            remaining_q <= cmd_steps_i;
            period_q    <= period_eff;
            if (cmd_steps_i == '0) begin
              done_o <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (abort_i) begin
            state_q <= IDLE;
          end else if (edge_tick) begin
            phase_q          <= phase_nxt;
            {ti1_o, ti2_o}   <= phase_to_ti(phase_nxt);
            pos_o            <= dir_q ? pos_o - CNT_W'(1) : pos_o + CNT_W'(1);
            remaining_q      <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q <= IDLE;
              done_o  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed testbench for quad_encoder_gen (CNT_W = 4 so position wrap is reachable).
module tb_quad_encoder_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_steps;
  logic [7:0] period;
  logic       abort;
  logic       ti1;
  logic       ti2;
  logic [3:0] pos;
  logic       busy;
  logic       done;
  logic [1:0] ti;

  int pass_cnt  = 0;
  int total_cnt = 0;

  assign ti = {ti1, ti2};

  quad_encoder_gen #(
    .CNT_W (4),
    .PER_W (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_dir_i   (cmd_dir),
    .cmd_steps_i (cmd_steps),
    .period_i    (period),
    .abort_i     (abort),
    .ti1_o       (ti1),
    .ti2_o       (ti2),
    .pos_o       (pos),
    .busy_o      (busy),
    .done_o      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance n clock edges; returns 1 time unit after the last rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one command; returns just after the accepting edge ("cycle 0").
  task automatic issue(input logic dir, input logic [3:0] steps, input logic [7:0] per);
    check("ready_before_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = steps;
    period    = per;
    step(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_steps = '0; period = '0; abort = 1'b0;

    // Reset state
    step(3);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_ti",    ti, 2'b00);
    check("rst_pos",   pos, 4'h0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", cmd_ready, 1);

    // Up: period 3, 4 steps -> edges at cycles 3,6,9,12
    issue(1'b0, 4'd4, 8'd3);
    check("up_c0_busy", busy, 1);
    check("up_c0_ready", cmd_ready, 0);
    step(2);
    check("up_c2_ti", ti, 2'b00);
    check("up_c2_pos", pos, 4'd0);
    step(1);
    check("up_c3_ti", ti, 2'b10);
    check("up_c3_pos", pos, 4'd1);
    step(3);
    check("up_c6_ti", ti, 2'b11);
    check("up_c6_pos", pos, 4'd2);
    step(3);
    check("up_c9_ti", ti, 2'b01);
    check("up_c9_pos", pos, 4'd3);
    step(2);
    check("up_c11_busy", busy, 1);
    check("up_c11_done", done, 0);
    step(1);
    check("up_c12_ti", ti, 2'b00);
    check("up_c12_pos", pos, 4'd4);
    check("up_c12_done", done, 1);
    check("up_c12_busy", busy, 0);
    step(1);
    check("up_c13_done", done, 0);

    // Bring position back to 0 with 4 fast down edges (phase 0 -> 0)
    issue(1'b1, 4'd4, 8'd1);
    step(4);
    check("rewind_pos", pos, 4'd0);
    check("rewind_ti", ti, 2'b00);

    // Down 2 then up 2, period 1: pos 0,-1,-2,-1,0
    issue(1'b1, 4'd2, 8'd1);
    check("dn_c0_pos", pos, 4'h0);
    step(1);
    check("dn_c1_ti", ti, 2'b01);
    check("dn_c1_pos", pos, 4'hF);
    step(1);
    check("dn_c2_ti", ti, 2'b11);
    check("dn_c2_pos", pos, 4'hE);
    check("dn_c2_done", done, 1);
    issue(1'b0, 4'd2, 8'd1);
    check("upb_c0_ti", ti, 2'b11);
    step(1);
    check("upb_c1_ti", ti, 2'b01);
    check("upb_c1_pos", pos, 4'hF);
    step(1);
    check("upb_c2_ti", ti, 2'b00);
    check("upb_c2_pos", pos, 4'h0);
    check("upb_c2_done", done, 1);

    // Zero steps: no edge, immediate done, never busy
    step(1);
    issue(1'b0, 4'd0, 8'd5);
    check("zero_busy", busy, 0);
    check("zero_done", done, 1);
    check("zero_ti", ti, 2'b00);
    step(1);
    check("zero_done_clr", done, 0);
    check("zero_pos", pos, 4'd0);

    // Enable low blocks commands; abort in IDLE does nothing
    en = 1'b0;
    #1;
    check("en_low_ready", cmd_ready, 0);
    en = 1'b1;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("idle_abort_pos", pos, 4'd0);
    check("idle_abort_busy", busy, 0);

    // Pause: period 4, 10 steps; en low 7 cycles after first edge
    issue(1'b0, 4'd10, 8'd4);
    step(4);
    check("pz_c4_pos", pos, 4'd1);
    check("pz_c4_ti", ti, 2'b10);
    en = 1'b0;
    step(7);
    check("pz_c11_pos", pos, 4'd1);
    check("pz_c11_busy", busy, 1);
    en = 1'b1;
    step(3);
    check("pz_c14_pos", pos, 4'd1);
    step(1);
    check("pz_c15_pos", pos, 4'd2);
    check("pz_c15_ti", ti, 2'b11);
    step(3);
    abort = 1'b1;   // edge due at cycle 19
    step(1);
    abort = 1'b0;
    check("ab_pos", pos, 4'd2);
    check("ab_ti", ti, 2'b11);
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    step(1);
    check("ab_done_next", done, 0);

    // Wrap: walk pos to 7, then one up edge with period 0 -> -8
    issue(1'b0, 4'd5, 8'd1);
    step(5);
    check("wr_pos7", pos, 4'd7);
    check("wr_ti", ti, 2'b01);
    issue(1'b0, 4'd1, 8'd0);
    step(1);
    check("wr_pos_m8", pos, 4'h8);
    check("wr_ti_0", ti, 2'b00);
    check("wr_done", done, 1);
    issue(1'b0, 4'd3, 8'd0);
    step(1);
    check("p0_c1_pos", pos, 4'h9);
    check("p0_c1_ti", ti, 2'b10);
    step(1);
    check("p0_c2_pos", pos, 4'hA);
    check("p0_c2_ti", ti, 2'b11);
    step(1);
    check("p0_c3_pos", pos, 4'hB);
    check("p0_c3_ti", ti, 2'b01);
    check("p0_c3_done", done, 1);

    // Reset mid-run, then a fresh command right after
    step(1);
    issue(1'b1, 4'd8, 8'd2);
    step(2);
    check("mr_c2_pos", pos, 4'hA);
    check("mr_c2_ti", ti, 2'b11);
    step(1);
    rst = 1'b1;
    step(1);
    check("mr_rst_pos", pos, 4'h0);
    check("mr_rst_ti", ti, 2'b00);
    check("mr_rst_busy", busy, 0);
    check("mr_rst_done", done, 0);
    check("mr_rst_ready", cmd_ready, 0);
    rst = 1'b0;
    #1;
    issue(1'b0, 4'd1, 8'd1);
    step(1);
    check("mr_new_pos", pos, 4'd1);
    check("mr_new_ti", ti, 2'b10);
    check("mr_new_done", done, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
